// File: rtl/dff_demux_pkg.sv
// dff_demux_pkg: shared constants, select type and decode helper for the 1:4 registered demux
package dff_demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_t s);
        return NUM_OUT'(1) << s;
    endfunction

endpackage

// File: rtl/dff_demux_if.sv
// dff_demux_if: input valid/ready handshake plus four per-channel output handshakes
interface dff_demux_if
    import dff_demux_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    sel_t                     in_sel;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dff_demux_slot.sv
// dff_demux_slot: one-entry output holding register; a load wins over a drain so
// back-to-back words pass without a bubble
module dff_demux_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dff_demux_1x4.sv
// dff_demux_1x4: registered 1:4 demux; a route register feeds four independent
// holding slots, and a blocked route word stalls the input for every channel
module dff_demux_1x4
    import dff_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic         clk,
    input logic         rst_n,
    dff_demux_if.slave  bus
);

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_data;
    sel_t               s1_sel;
    logic               s1_adv;
    logic               accept;
    logic [NUM_OUT-1:0] slot_valid;
    logic [NUM_OUT-1:0] load;

    // in_ready depends only on stage state and out_ready, never on in_valid
    assign s1_adv       = s1_valid && (!slot_valid[s1_sel] || bus.out_ready[s1_sel]);
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = s1_adv ? sel_onehot(s1_sel) : '0;
    assign bus.out_valid = slot_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sel   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= bus.in_data;
            s1_sel   <= bus.in_sel;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        dff_demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (s1_data),
            .ready     (bus.out_ready[k]),
            .valid     (slot_valid[k]),
            .data      (bus.out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule
